// File: rtl/timing_unit.sv
// Instruction timing generator: a one-hot t0..t7 sequence per instruction, whose
// length depends on the opcode latched at t2, with halt, abort and a completed-instruction count.
module timing_unit #(
   parameter logic [2:0] HALT_OP = 3'b111
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic       halt_req,
   input  logic       abort,
   input  logic [2:0] op,
   output logic       t0,
   output logic       t1,
   output logic       t2,
   output logic       t3,
   output logic       t4,
   output logic       t5,
   output logic       t6,
   output logic       t7,
   output logic       q1,
   output logic       q2,
   output logic       q3,
   output logic       running,
   output logic       done,
   output logic [7:0] icount
);

   logic [2:0] sc_q, sc_d;
   logic [2:0] ir_q, ir_d;
   logic       run_q, run_d;
   logic       hp_q, hp_d;
   logic [7:0] ic_q, ic_d;
   logic [2:0] last;
   logic [7:0] tvec;

   // Last timing cycle depends on the opcode class; t0..t2 never reach it since last >= 3.
   always_comb begin
      unique case (ir_q)
         3'd2:    last = 3'd5;
         3'd3:    last = 3'd7;
         default: last = 3'd3;
      endcase
   end

   always_comb begin
      sc_d  = sc_q;
      ir_d  = ir_q;
      run_d = run_q;
      hp_d  = hp_q;
      ic_d  = ic_q;
      if (!run_q) begin
         if (start) begin
            run_d = 1'b1;
            sc_d  = 3'd0;
         end
      end else if (abort) begin
         sc_d = 3'd0;
      end else if (sc_q == last) begin
         sc_d = 3'd0;
         ic_d = ic_q + 8'd1;
         hp_d = 1'b0;
         if (hp_q || halt_req || (ir_q == HALT_OP)) run_d = 1'b0;
      end else begin
         sc_d = sc_q + 3'd1;
         if (sc_q == 3'd2) ir_d = op;
         if (halt_req) hp_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sc_q  <= 3'd0;
         ir_q  <= 3'd0;
         run_q <= 1'b0;
         hp_q  <= 1'b0;
         ic_q  <= 8'd0;
      end else begin
         sc_q  <= sc_d;
         ir_q  <= ir_d;
         run_q <= run_d;
         hp_q  <= hp_d;
         ic_q  <= ic_d;
      end
   end

   assign tvec = run_q ? (8'd1 << sc_q) : 8'd0;
   assign {t7, t6, t5, t4, t3, t2, t1, t0} = tvec;
   assign q1      = (ir_q == 3'd1);
   assign q2      = (ir_q == 3'd2);
   assign q3      = (ir_q == 3'd3);
   assign running = run_q;
   assign done    = run_q && (sc_q == last);
   assign icount  = ic_q;

endmodule

// File: tb/tb_timing_unit.sv
// Table-driven bench for timing_unit: hand-written expected outputs per cycle,
// queued when a vector is driven and compared once the cycle's outputs settle.
module tb_timing_unit;

   typedef struct packed {
      logic       st;
      logic       hr;
      logic       ab;
      logic [2:0] op;
      logic [7:0] t;
      logic [2:0] q;
      logic       run;
      logic       dn;
      logic [7:0] ic;
   } vec_t;

   logic       clk, rst_n, start, halt_req, abort;
   logic [2:0] op;
   logic       t0, t1, t2, t3, t4, t5, t6, t7, q1, q2, q3, running, done;
   logic [7:0] icount;

   int   errors = 0;
   int   checks = 0;
   vec_t tbl[$];
   vec_t sb[$];

   timing_unit #(.HALT_OP(3'b111)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .halt_req(halt_req), .abort(abort), .op(op),
      .t0(t0), .t1(t1), .t2(t2), .t3(t3), .t4(t4), .t5(t5), .t6(t6), .t7(t7),
      .q1(q1), .q2(q2), .q3(q3), .running(running), .done(done), .icount(icount)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic vec_t mk(input logic st, input logic hr, input logic ab, input logic [2:0] o,
                               input int tn, input logic [2:0] q, input logic run, input logic dn,
                               input int ic);
      vec_t v;
      v.st = st; v.hr = hr; v.ab = ab; v.op = o;
      v.t  = (tn < 0) ? 8'd0 : (8'd1 << tn);
      v.q  = q; v.run = run; v.dn = dn; v.ic = ic[7:0];
      return v;
   endfunction

   function automatic logic [21:0] outs();
      return {t7, t6, t5, t4, t3, t2, t1, t0, q3, q2, q1, running, done, icount};
   endfunction

   task automatic chk(input string name, input logic [21:0] act, input logic [21:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got t=%b q=%b run=%b done=%b ic=%0d, want t=%b q=%b run=%b done=%b ic=%0d",
                  name, act[21:14], act[13:11], act[10], act[9], act[7:0],
                  exp[21:14], exp[13:11], exp[10], exp[9], exp[7:0]);
      end
   endtask

   task automatic apply(input vec_t v, input string name);
      vec_t e;
      @(negedge clk);
      start = v.st; halt_req = v.hr; abort = v.ab; op = v.op;
      sb.push_back(v);
      #1;
      e = sb.pop_front();
      chk(name, outs(), {e.t, e.q, e.run, e.dn, e.ic});
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; halt_req = 1'b0; abort = 1'b0; op = 3'd0;

      // idle, abort and start while idle
      tbl.push_back(mk(0,0,0,0,-1,0,0,0,0));
      tbl.push_back(mk(0,0,1,0,-1,0,0,0,0));
      tbl.push_back(mk(1,0,0,0,-1,0,0,0,0));
      // op=1: t0..t3, start ignored while running
      tbl.push_back(mk(1,0,0,0,0,0,1,0,0));
      tbl.push_back(mk(0,0,0,0,1,0,1,0,0));
      tbl.push_back(mk(0,0,0,1,2,0,1,0,0));
      tbl.push_back(mk(0,0,0,0,3,1,1,1,0));
      // op=3: t0..t7
      tbl.push_back(mk(0,0,0,0,0,1,1,0,1));
      tbl.push_back(mk(0,0,0,0,1,1,1,0,1));
      tbl.push_back(mk(0,0,0,3,2,1,1,0,1));
      for (int n = 3; n <= 6; n++) tbl.push_back(mk(0,0,0,0,n,4,1,0,1));
      tbl.push_back(mk(0,0,0,0,7,4,1,1,1));
      // op=2 with halt_req at t1: completes through t5 then stops
      tbl.push_back(mk(0,0,0,0,0,4,1,0,2));
      tbl.push_back(mk(0,1,0,0,1,4,1,0,2));
      tbl.push_back(mk(0,0,0,2,2,4,1,0,2));
      tbl.push_back(mk(0,0,0,0,3,2,1,0,2));
      tbl.push_back(mk(0,0,0,0,4,2,1,0,2));
      tbl.push_back(mk(0,0,0,0,5,2,1,1,2));
      tbl.push_back(mk(0,1,0,0,-1,2,0,0,3));
      tbl.push_back(mk(1,0,0,0,-1,2,0,0,3));
      // HALT_OP
      tbl.push_back(mk(0,0,0,0,0,2,1,0,3));
      tbl.push_back(mk(0,0,0,0,1,2,1,0,3));
      tbl.push_back(mk(0,0,0,7,2,2,1,0,3));
      tbl.push_back(mk(1,0,0,0,3,0,1,1,3));
      tbl.push_back(mk(1,0,1,0,-1,0,0,0,4));
      // op=3 aborted at t4, then op=1
      tbl.push_back(mk(0,0,0,0,0,0,1,0,4));
      tbl.push_back(mk(0,0,0,0,1,0,1,0,4));
      tbl.push_back(mk(0,0,0,3,2,0,1,0,4));
      tbl.push_back(mk(0,0,0,0,3,4,1,0,4));
      tbl.push_back(mk(0,0,1,0,4,4,1,0,4));
      tbl.push_back(mk(0,0,0,0,0,4,1,0,4));
      tbl.push_back(mk(0,0,0,0,1,4,1,0,4));
      tbl.push_back(mk(0,0,0,1,2,4,1,0,4));
      tbl.push_back(mk(0,0,0,0,3,1,1,1,4));
      // op=1 with halt_req in the last cycle
      tbl.push_back(mk(0,0,0,0,0,1,1,0,5));
      tbl.push_back(mk(0,0,0,0,1,1,1,0,5));
      tbl.push_back(mk(0,0,0,1,2,1,1,0,5));
      tbl.push_back(mk(0,1,0,0,3,1,1,1,5));
      tbl.push_back(mk(0,0,0,0,-1,1,0,0,6));

      #3;
      chk("reset_state", outs(), 22'd0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < tbl.size(); i++) apply(tbl[i], $sformatf("vec%0d", i));

      // icount wrap: 250 more op=1 instructions bring 6 up to 256 -> 0
      apply(mk(1,0,0,0,-1,1,0,0,6), "wrap_start");
      for (int k = 0; k < 250; k++)
         for (int c = 0; c < 4; c++)
            apply(mk(0, (k == 249 && c == 3), 0, (c == 2) ? 3'd1 : 3'd0, c, 1, 1, (c == 3), (6 + k) % 256),
                  $sformatf("wrap_k%0d_t%0d", k, c));
      apply(mk(0,0,0,0,-1,1,0,0,0), "wrap_zero");

      // asynchronous reset during t5 of an op=2 instruction
      apply(mk(1,0,0,0,-1,1,0,0,0), "rst_seq_start");
      apply(mk(0,0,0,0,0,1,1,0,0), "rst_seq_t0");
      apply(mk(0,0,0,0,1,1,1,0,0), "rst_seq_t1");
      apply(mk(0,0,0,2,2,1,1,0,0), "rst_seq_t2");
      apply(mk(0,0,0,0,3,2,1,0,0), "rst_seq_t3");
      apply(mk(0,0,0,0,4,2,1,0,0), "rst_seq_t4");
      apply(mk(0,0,0,0,5,2,1,1,0), "rst_seq_t5");
      rst_n = 1'b0;
      #1;
      chk("async_reset_immediate", outs(), 22'd0);
      @(posedge clk);
      #1;
      chk("reset_held", outs(), 22'd0);
      @(negedge clk);
      rst_n = 1'b1;
      apply(mk(0,0,0,0,-1,0,0,0,0), "post_reset_idle0");
      apply(mk(0,0,0,0,-1,0,0,0,0), "post_reset_idle1");
      apply(mk(1,0,0,0,-1,0,0,0,0), "post_reset_start");
      apply(mk(0,0,0,0,0,0,1,0,0), "post_reset_t0");
      apply(mk(0,0,0,0,1,0,1,0,0), "post_reset_t1");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
